// File: rtl/melody_sequencer.sv
// Square-wave melody player: steps through an external note table, producing a tone
// or a rest for each entry, with an optional silent gap between notes.
module melody_sequencer #(
  parameter int UNIT_CYCLES = 8333333,
  parameter int SONG_LEN    = 70,
  parameter int PERIOD_W    = 20,
  parameter int DUR_W       = 5,
  parameter int GAP_CYCLES  = 0,
  parameter int ADDR_W      = 10
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic                loop_en,
  output logic [ADDR_W-1:0]   note_addr,
  input  logic [PERIOD_W-1:0] note_period,
  input  logic [DUR_W-1:0]    note_dur,
  output logic                audio_out,
  output logic                aud_sd,
  output logic                busy,
  output logic                done
);

  localparam int UNIT_W  = $clog2(UNIT_CYCLES + 1);
  localparam int TIMER_W = DUR_W + UNIT_W;
  localparam int GAP_W   = $clog2(GAP_CYCLES + 2);
  localparam bit NO_GAP  = (GAP_CYCLES == 0);
  localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(SONG_LEN - 1);
  localparam logic [TIMER_W-1:0] UNIT_T    = TIMER_W'(UNIT_CYCLES);
  localparam logic [GAP_W-1:0]   GAP_LOAD  = GAP_W'(GAP_CYCLES);

  typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;

  state_t              state;
  logic [PERIOD_W-1:0] period_q;
  logic [PERIOD_W-1:0] tone_cnt;
  logic [TIMER_W-1:0]  dur_cnt;
  logic [GAP_W-1:0]    gap_cnt;
  logic [TIMER_W-1:0]  dur_product;
  logic                at_last;
  logic                note_over;
  logic                song_end;
  logic                advance;

  // Full-width product so the longest note never truncates.
  assign dur_product = TIMER_W'(note_dur) * UNIT_T;
  assign at_last     = (note_addr == LAST_ADDR);
  assign note_over   = (state == PLAY && dur_cnt == TIMER_W'(1) && NO_GAP) ||
                       (state == GAP && gap_cnt == GAP_W'(1));
  assign song_end    = (state == LOAD && note_dur == '0) || (note_over && at_last);
  assign advance     = note_over && !at_last;

  always_ff @(posedge clock) begin
    done <= 1'b0;
    if (reset || stop) begin
      state     <= IDLE;
      note_addr <= '0;
      audio_out <= 1'b0;
      busy      <= 1'b0;
      aud_sd    <= 1'b0;
      tone_cnt  <= '0;
      dur_cnt   <= '0;
      gap_cnt   <= '0;
    end else if (song_end) begin
      audio_out <= 1'b0;
      note_addr <= '0;
      if (loop_en) begin
        state <= LOAD;
      end else begin
        state  <= IDLE;
        busy   <= 1'b0;
        aud_sd <= 1'b0;
        done   <= 1'b1;
      end
    end else if (advance) begin
      audio_out <= 1'b0;
      note_addr <= note_addr + ADDR_W'(1);
      state     <= LOAD;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= LOAD;
            busy      <= 1'b1;
            aud_sd    <= 1'b1;
            note_addr <= '0;
          end
        end
        LOAD: begin
          period_q  <= note_period;
          dur_cnt   <= dur_product;
          tone_cnt  <= '0;
          audio_out <= 1'b0;
          state     <= PLAY;
        end
        PLAY: begin
          // Only reached on the last PLAY cycle when a gap is configured.
          if (dur_cnt == TIMER_W'(1)) begin
            audio_out <= 1'b0;
            tone_cnt  <= '0;
            gap_cnt   <= GAP_LOAD;
            state     <= GAP;
          end else begin
            dur_cnt <= dur_cnt - TIMER_W'(1);
            if (period_q != '0) begin
              if (tone_cnt == period_q - PERIOD_W'(1)) begin
                tone_cnt  <= '0;
                audio_out <= ~audio_out;
              end else begin
                tone_cnt <= tone_cnt + PERIOD_W'(1);
              end
            end
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt - GAP_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
